// File: rtl/frame_stream_scheduler.sv
`default_nettype none
// ============================================================================
// frame_stream_scheduler
//   Raster read sequencer for the frame buffer with credit-limited show-ahead
//   output FIFO and SOP/EOP-tagged valid/ready pixel stream.
// Revision: 1.0
// ============================================================================
module frame_stream_scheduler #(
   parameter int WIDTH      = 320,
   parameter int HEIGHT     = 240,
   parameter int ADDR_W     = 17,
   parameter int DATA_W     = 30,
   parameter int RD_LAT     = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [2:0]        mode_req,
   output logic [2:0]        mode_active,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] pix_in,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              out_sop,
   output logic              out_eop,
   output logic              frame_done,
   output logic [15:0]       frame_count
);

   localparam int COL_W = $clog2(WIDTH + 1);
   localparam int ROW_W = $clog2(HEIGHT + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH + RD_LAT + 2) + 1;
   localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(FIFO_DEPTH - 1);
   localparam bit SINGLE_PIX = (WIDTH * HEIGHT == 1);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_STREAM = 2'd1;
   localparam logic [1:0] S_FLUSH  = 2'd2;

   logic [1:0]        state, state_nxt;
   logic [COL_W-1:0]  col, next_col;
   logic [ROW_W-1:0]  row, next_row;
   logic              next_is_last;
   logic              start, advance;
   logic              push, pop, eop_accept, credit;
   logic [OCC_W-1:0]  inflight, occ;
   logic [RD_LAT:1]   tag_v, tag_s, tag_e;
   logic              sop0, eop0;
   logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0] mem_s, mem_e;
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [CNT_W-1:0]  fifo_count;

   // col/row describe the read currently on rd_addr
   always_comb begin
      next_col = col + COL_W'(1);
      next_row = row;
      if (col == LAST_COL) begin
         next_col = '0;
         next_row = row + ROW_W'(1);
      end
   end

   assign next_is_last = (next_col == LAST_COL) && (next_row == LAST_ROW);
   assign sop0 = (col == '0) && (row == '0);
   assign eop0 = (col == LAST_COL) && (row == LAST_ROW);

   assign out_valid  = (fifo_count != '0);
   assign out_data   = mem_d[rd_ptr];
   assign out_sop    = out_valid & mem_s[rd_ptr];
   assign out_eop    = out_valid & mem_e[rd_ptr];
   assign pop        = out_valid & out_ready;
   assign push       = tag_v[RD_LAT];
   assign eop_accept = pop & out_eop;

   // Occupancy after this edge's pop; the read about to issue must still fit
   always_comb begin
      inflight = OCC_W'(rd_en);
      for (int i = 1; i <= RD_LAT; i++) begin
         inflight = inflight + OCC_W'(tag_v[i]);
      end
   end

   assign occ    = OCC_W'(fifo_count) - OCC_W'(pop) + inflight;
   assign credit = (occ < OCC_W'(FIFO_DEPTH));

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (enable) state_nxt = SINGLE_PIX ? S_FLUSH : S_STREAM;
         S_STREAM: if (credit && next_is_last) state_nxt = S_FLUSH;
         S_FLUSH:  if (eop_accept) begin
                      if (enable) state_nxt = SINGLE_PIX ? S_FLUSH : S_STREAM;
                      else        state_nxt = S_IDLE;
                   end
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      start   = 1'b0;
      advance = 1'b0;
      case (state)
         S_IDLE:   start   = enable;
         S_STREAM: advance = credit;
         S_FLUSH:  start   = eop_accept & enable;
         default:  ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_en       <= 1'b0;
         rd_addr     <= '0;
         col         <= '0;
         row         <= '0;
         mode_active <= '0;
      end else begin
         rd_en <= start | advance;
         if (start) begin
            rd_addr     <= '0;
            col         <= '0;
            row         <= '0;
            mode_active <= mode_req;
         end else if (advance) begin
            rd_addr <= rd_addr + ADDR_W'(1);
            col     <= next_col;
            row     <= next_row;
         end
      end
   end

   // Tag stage k holds the read issued k cycles earlier; stage RD_LAT meets pix_in
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tag_v <= '0;
         tag_s <= '0;
         tag_e <= '0;
      end else begin
         tag_v[1] <= rd_en;
         tag_s[1] <= sop0;
         tag_e[1] <= eop0;
         for (int i = 2; i <= RD_LAT; i++) begin
            tag_v[i] <= tag_v[i-1];
            tag_s[i] <= tag_s[i-1];
            tag_e[i] <= tag_e[i-1];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         mem_s      <= '0;
         mem_e      <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) mem_d[i] <= '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr] <= pix_in;
            mem_s[wr_ptr] <= tag_s[RD_LAT];
            mem_e[wr_ptr] <= tag_e[RD_LAT];
            wr_ptr        <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         end
         if (pop) rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_done  <= 1'b0;
         frame_count <= '0;
      end else begin
         frame_done <= eop_accept;
         if (eop_accept) frame_count <= frame_count + 16'd1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_frame_stream_scheduler.sv
`default_nettype none
// ============================================================================
// tb_frame_stream_scheduler
//   Directed bench for a 4x2 frame: frame-buffer model, beat-order model, and
//   literal timing/mode expectations.
// Revision: 1.0
// ============================================================================
module tb_frame_stream_scheduler;

   localparam int W = 4;
   localparam int H = 2;
   localparam int N = W * H;
   localparam int RD_LAT = 2;
   localparam int FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        enable;
   logic [2:0]  mode_req;
   logic [2:0]  mode_active;
   logic        rd_en;
   logic [16:0] rd_addr;
   logic [29:0] pix_in = '0;
   logic [29:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        out_sop;
   logic        out_eop;
   logic        frame_done;
   logic [15:0] frame_count;

   frame_stream_scheduler #(
      .WIDTH(W), .HEIGHT(H), .ADDR_W(17), .DATA_W(30),
      .RD_LAT(RD_LAT), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .enable(enable), .mode_req(mode_req),
      .mode_active(mode_active), .rd_en(rd_en), .rd_addr(rd_addr),
      .pix_in(pix_in), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop),
      .frame_done(frame_done), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   int compared = 0;
   int mismatched = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [29:0] pix_of(input int a);
      logic [29:0] v;
      v = 30'(a * 7919 + 12345);
      return v;
   endfunction

   // Frame buffer: data for a read seen in cycle n is presented during cycle n+RD_LAT
   bit          h_en   [0:RD_LAT];
   logic [16:0] h_addr [0:RD_LAT];
   always @(posedge clk) begin
      #1;
      for (int i = RD_LAT; i > 0; i--) begin
         h_en[i]   = h_en[i-1];
         h_addr[i] = h_addr[i-1];
      end
      h_en[0]   = rd_en;
      h_addr[0] = rd_addr;
      pix_in    = h_en[RD_LAT] ? pix_of(int'(h_addr[RD_LAT])) : 30'h3BADBAD;
   end

   logic [2:0] mode_q;
   always @(posedge clk) mode_q <= mode_req;

   // Stream model: beats of a frame are pixels 0..N-1 in raster order
   int exp_idx = 0, exp_addr = 0, issued = 0, popped = 0, exp_frames = 0;
   bit done_due = 1'b0;
   logic [2:0] exp_mode = '0;
   int cyc = 0;
   int t_first = 0, t_last = 0, t_done = 0, t_sop = 0, t_eop = 0;
   logic [2:0] m_first = '0, m_eop = '0;

   always @(negedge clk) begin
      cyc++;
      if (reset) begin
         exp_idx = 0; exp_addr = 0; issued = 0; popped = 0;
         exp_frames = 0; done_due = 1'b0; exp_mode = '0;
      end else begin
         check("frame_done", frame_done, done_due);
         if (done_due) check("frame_count", frame_count, exp_frames);
         if (frame_done) t_done = cyc;
         done_due = 1'b0;
         if (rd_en) begin
            check("rd_addr", rd_addr, exp_addr);
            if (exp_addr == 0) begin
               exp_mode = mode_q;
               t_first  = cyc;
               m_first  = mode_active;
            end
            if (exp_addr == N - 1) t_last = cyc;
            exp_addr = (exp_addr + 1) % N;
            issued++;
            check("credit_bound", (issued - popped) <= FIFO_DEPTH, 1'b1);
         end
         if (rd_en || out_valid) check("mode_active", mode_active, exp_mode);
         if (out_valid && out_ready) begin
            check("out_data", out_data, pix_of(exp_idx));
            check("out_sop", out_sop, exp_idx == 0);
            check("out_eop", out_eop, exp_idx == N - 1);
            if (exp_idx == 0) t_sop = cyc;
            popped++;
            if (exp_idx == N - 1) begin
               exp_frames++;
               done_due = 1'b1;
               t_eop    = cyc;
               m_eop    = mode_active;
            end
            exp_idx = (exp_idx + 1) % N;
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_rd_en"},       rd_en, 0);
      check({tag, "_rd_addr"},     rd_addr, 0);
      check({tag, "_out_valid"},   out_valid, 0);
      check({tag, "_out_sop"},     out_sop, 0);
      check({tag, "_out_eop"},     out_eop, 0);
      check({tag, "_frame_done"},  frame_done, 0);
      check({tag, "_mode_active"}, mode_active, 0);
      check({tag, "_frame_count"}, frame_count, 0);
      check({tag, "_out_data"},    out_data, 0);
   endtask

   task automatic wait_frames(input int target, input string name);
      int k = 0;
      while (frame_count < 16'(target) && k < 400) begin
         @(posedge clk); #1; k++;
      end
      check(name, frame_count, target);
   endtask

   task automatic wait_beats(input int n, input string name);
      int k = 0;
      while (exp_idx < n && k < 200) begin
         @(posedge clk); #1; k++;
      end
      check(name, exp_idx >= n, 1'b1);
   endtask

   initial begin
      int f0_first, f0_last, nz, k;
      reset = 1'b1; enable = 1'b0; out_ready = 1'b1; mode_req = 3'd2;
      repeat (3) @(posedge clk);
      #1 check_all_zero("reset");
      reset = 1'b0;
      @(posedge clk); #1 enable = 1'b1;

      // Mode menu change while frame 0 beat 3 is on the output
      wait_beats(2, "wait_beat3");
      mode_req = 3'd1;
      wait_frames(1, "frame0_done");
      f0_first = t_first;
      f0_last  = t_last;
      @(negedge clk); #1;
      check("first_frame_latency", t_done - f0_first, 11);
      check("frame_gap", t_first - f0_last, 4);
      check("mode_next_frame", m_first, 3'd1);
      check("mode_through_eop", m_eop, 3'd2);

      // Backpressure from the first read of frame 2
      wait_frames(2, "frame1_done");
      out_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("stall_outstanding", issued - popped, 4);
      check("stall_no_read", rd_en, 0);
      out_ready = 1'b1;

      // Alternating ready for frame 3
      wait_frames(3, "frame2_done");
      k = 0;
      while (frame_count < 16'd4 && k < 200) begin
         out_ready = ~out_ready;
         @(posedge clk); #1; k++;
      end
      out_ready = 1'b1;
      check("toggle_frame_done", frame_count, 4);
      check("toggle_throughput", t_eop - t_sop, 14);

      // enable drops during beat 5 of frame 4
      wait_beats(4, "wait_beat5");
      enable = 1'b0;
      wait_frames(5, "drop_frame_done");
      nz = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (rd_en || out_valid) nz++;
      end
      check("idle_after_drop", nz, 0);

      // Asynchronous reset in the middle of a frame
      enable = 1'b1;
      wait_beats(3, "wait_reset_point");
      #2 reset = 1'b1;
      #1 check_all_zero("async_reset");
      @(posedge clk); @(posedge clk); #1 reset = 1'b0;
      wait_frames(1, "post_reset_frame");

      repeat (5) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
`default_nettype wire
